// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB first with a registered carry,
// framed by a start/busy/done handshake. Result is {cout, sum} = a + b + cin.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic bitSum;
  logic carryOut;
  logic lastBit;

  assign bitSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
  assign carryOut = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
  assign lastBit  = (count_q == CW'(WIDTH - 1));

  // On the last bit, carry_q is the carry into the MSB, so overflow falls out directly.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = cin;
          count_d = '0;
          psum_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        psum_d  = {bitSum, psum_q[WIDTH-1:1]};
        carry_d = carryOut;
        count_d = count_q + CW'(1);
        if (lastBit) begin
          sum_d   = {bitSum, psum_q[WIDTH-1:1]};
          cout_d  = carryOut;
          ovf_d   = carry_q ^ carryOut;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, the additive counterpart of the team's gate-level full subtractor datapath.
- One full-adder cell is reused once per clock, LSB first, with a registered carry.
- A start/busy/done handshake frames each operation.
- Sits beside the subtractor blocks as the area-minimal add path for multi-cycle arithmetic units.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry out of MSB
- ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset: clk and rst_n are the only clock/reset; reset is synchronous, active-low. When rst_n=0 at a rising edge:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0, ovf=0;
  - internal shift registers, carry and bit counter cleared.
  - Reset overrides all other inputs, including mid-RUN; the partial operation is discarded and nothing is written to sum.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 -> load a, b into shift registers; carry<=cin; count<=0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN, at each edge Ek, k=1..WIDTH:
  - s = a_sh[0]^b_sh[0]^carry;
  - carry <= majority(a_sh[0], b_sh[0], carry);
  - a_sh, b_sh shift right by 1;
  - s shifts into MSB of the partial-sum register;
  - count increments.
  - Carry into the MSB is captured when count = WIDTH-1.
  - At EWIDTH: sum <= completed partial-sum register; cout <= final carry; ovf <= captured MSB carry-in XOR final carry; go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE with done=0.
- Latency: done is high in the cycle following edge EWIDTH, i.e. WIDTH edges after the accepting edge E0.
- Minimum start-to-start interval is WIDTH+2 cycles.
- busy=1 exactly in RUN (WIDTH cycles); busy=0 in IDLE and DONE.
- start asserted in RUN or DONE is ignored, not queued.
- Operand inputs a, b, cin are don't-care except at the accepting edge; changes during RUN have no effect.
- sum, cout and ovf change only at EWIDTH, or on reset; they hold their previous values throughout RUN.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- ovf is valid for two's-complement interpretation of a, b.
- Counter width is clog2(WIDTH)+1; no wrap occurs within one operation.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulse -> busy high 8 cycles; done pulse 8 edges after accept; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Start a=0x11, b=0x22; at the 3rd RUN cycle pulse start with a=0xFF and change the a/b inputs -> result sum=0x33, cout=0; exactly one done pulse; second start not executed.
- Start a=0x55, b=0x55 (previous sum=0x33); drive rst_n=0 for 1 cycle at the 4th RUN cycle -> next cycle IDLE, busy=0, done=0, sum=0x00, cout=0, ovf=0; no done pulse follows.
- Random regression, 1000 ops at WIDTH=8 and WIDTH=16 -> {cout, sum} matches a+b+cin and ovf matches the signed reference every time; done count equals accepted start count.
